// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: width helpers, event layout, scan FSM states.
package keypad_pkg;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits
  function automatic int unsigned idx_width(input int unsigned v);
    return (clog2_f(v) < 1) ? 1 : clog2_f(v);
  endfunction

  // Event word: release flag in the MSB, key code in the bits below it
  function automatic logic [31:0] evt_pack(input int unsigned kw, input logic [31:0] code,
                                           input logic rel);
    return (32'(rel) << kw) | code;
  endfunction

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EVAL   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event stream: valid/ready handshake carrying a key code and release flag.
interface keypad_scanner_if #(
  parameter int unsigned KW = 5
) ();
  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_code;
  logic          evt_release;

  modport master (output evt_valid, output evt_code, output evt_release, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_release, output evt_ready);
endinterface

// File: rtl/keypad_scanner_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned W     = 6,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW = idx_width(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (do_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-by-row matrix keypad scanner with per-key debounce and a press/release event FIFO.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 5,
  parameter int unsigned SETTLE     = 8,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [ROWS-1:0]        keyRow,
  input  logic [COLS-1:0]        keyCol,
  keypad_scanner_if.master       evt,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic                   any_pressed,
  output logic                   overflow
);
  localparam int unsigned NK  = ROWS * COLS;
  localparam int unsigned KW  = idx_width(NK);
  localparam int unsigned EW  = KW + 1;
  localparam int unsigned RW  = idx_width(ROWS);
  localparam int unsigned CLW = idx_width(COLS);
  localparam int unsigned SW  = idx_width(SETTLE);
  localparam int unsigned DW  = idx_width(DEBOUNCE + 1);

  scan_state_e             state_q;
  logic [SW-1:0]           settle_q;
  logic [RW-1:0]           row_q;
  logic [CLW-1:0]          col_q;
  logic                    drv_q;
  logic [COLS-1:0]         sync1_q;
  logic [COLS-1:0]         sync2_q;
  logic [COLS-1:0]         raw_q;
  logic [NK-1:0]           stable_q;
  logic [NK-1:0]           stable_d;
  logic [NK-1:0][DW-1:0]   cnt_q;
  logic [NK-1:0][DW-1:0]   cnt_d;
  logic                    any_q;
  logic                    ovf_q;

  logic [KW-1:0]           key_idx;
  logic                    raw_bit;
  logic                    push_c;
  logic                    push_rel_c;
  logic                    pop_c;
  logic [EW-1:0]           push_data;
  logic [EW-1:0]           head;
  logic                    fifo_full;
  logic                    fifo_empty;

  // Only the active row is pulled low; the rest float on the board pull-ups
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign keyRow[r] = (drv_q && (row_q == RW'(r))) ? 1'b0 : 1'bz;
  end

  assign key_idx = KW'(32'(row_q) * COLS + 32'(col_q));
  assign raw_bit = raw_q[col_q];

  // Debounce of the single key addressed in EVAL
  always_comb begin
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    push_c     = 1'b0;
    push_rel_c = 1'b0;
    if (state_q == ST_EVAL) begin
      if (raw_bit == stable_q[key_idx]) begin
        cnt_d[key_idx] = '0;
      end else if (cnt_q[key_idx] == DW'(DEBOUNCE - 1)) begin
        stable_d[key_idx] = raw_bit;
        cnt_d[key_idx]    = '0;
        push_c            = 1'b1;
        push_rel_c        = ~raw_bit;
      end else begin
        cnt_d[key_idx] = cnt_q[key_idx] + DW'(1);
      end
    end
  end

  assign pop_c     = evt.evt_valid & evt.evt_ready;
  assign push_data = EW'(evt_pack(KW, 32'(key_idx), push_rel_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      drv_q    <= 1'b0;
      sync1_q  <= '1;
      sync2_q  <= '1;
      raw_q    <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      any_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      drv_q    <= 1'b1;
      sync1_q  <= keyCol;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      any_q    <= |stable_d;
      if (push_c && fifo_full && !pop_c) ovf_q <= 1'b1;

      case (state_q)
        ST_SETTLE: begin
          if (settle_q == SW'(SETTLE - 1)) begin
            settle_q <= '0;
            state_q  <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        ST_SAMPLE: begin
          raw_q   <= ~sync2_q;
          col_q   <= '0;
          state_q <= ST_EVAL;
        end
        ST_EVAL: begin
          if (col_q == CLW'(COLS - 1)) begin
            col_q   <= '0;
            row_q   <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            state_q <= ST_SETTLE;
          end else begin
            col_q <= col_q + CLW'(1);
          end
        end
        default: state_q <= ST_SETTLE;
      endcase
    end
  end

  key_event_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (push_data),
    .pop_i   (pop_c),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt.evt_valid   = ~fifo_empty;
  assign evt.evt_code    = head[KW-1:0];
  assign evt.evt_release = head[KW];
  assign key_state       = stable_q;
  assign any_pressed     = any_q;
  assign overflow        = ovf_q;

endmodule
